// File: rtl/io_input_sampler_if.sv
// io_input_sampler_if
// Bundles the raw board inputs and the debounced outputs of io_input_sampler.
//   sw_raw            : 18 slide switches, asynchronous, active-high
//   key_raw           : 4 push-buttons, asynchronous, active-low
//   IO_input          : debounced levels, [17:0] switches, [21:18] keys, active-high
//   key_press_pulse   : one-cycle pulse per key on debounced press
//   key_release_pulse : one-cycle pulse per key on debounced release
//   sw_change         : one-cycle pulse when any debounced switch changes
// The master modport is the board side that drives the raw lines. The slave
// modport is the sampler that consumes them and produces the outputs.
interface io_input_sampler_if;
    logic [17:0] sw_raw;
    logic [3:0]  key_raw;
    logic [21:0] IO_input;
    logic [3:0]  key_press_pulse;
    logic [3:0]  key_release_pulse;
    logic        sw_change;

    modport master (
        output sw_raw,
        output key_raw,
        input  IO_input,
        input  key_press_pulse,
        input  key_release_pulse,
        input  sw_change
    );

    modport slave (
        input  sw_raw,
        input  key_raw,
        output IO_input,
        output key_press_pulse,
        output key_release_pulse,
        output sw_change
    );
endinterface

// File: rtl/io_input_sampler.sv
// io_input_sampler
// Synchronizes and debounces 18 switches and 4 push-buttons. It also
// produces registered edge pulses for the keys and a change pulse for the
// switches.
//   physical_clock : single clock; all state updates on the rising edge
//   reset          : synchronous, active-high
//   io (slave)     : sw_raw/key_raw in; IO_input, key_press_pulse,
//                    key_release_pulse and sw_change out (all registered)
// A level that is held stable appears on IO_input DEBOUNCE_CYCLES+2 edges
// after the first edge that samples it.
module io_input_sampler #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic              physical_clock,
    input  logic              reset,
    io_input_sampler_if.slave io
);
    localparam int unsigned NL = 22;
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [NL-1:0]         raw_hi;
    logic [NL-1:0]         sync1;
    logic [NL-1:0]         sync2;
    logic [NL-1:0]         deb;
    logic [NL-1:0]         deb_next;
    logic [NL-1:0][CW-1:0] cnt;
    logic [NL-1:0][CW-1:0] cnt_next;
    logic [3:0]            press_q;
    logic [3:0]            release_q;
    logic                  sw_change_q;

    // Keys are inverted here, so every internal level is active-high.
    // The reset value 0 therefore means "not pressed" for the keys as well.
    assign raw_hi = {~io.key_raw, io.sw_raw};

    // Per-line stability counter. A mismatch between the synchronized level
    // and the debounced level must persist DEBOUNCE_CYCLES consecutive edges
    // before it is accepted. Any agreement clears the count, so the count
    // never wraps.
    always_comb begin
        deb_next = deb;
        cnt_next = '0;
        for (int unsigned i = 0; i < NL; i++) begin
            if (sync2[i] != deb[i]) begin
                if (cnt[i] == CNT_MAX) begin
                    deb_next[i] = sync2[i];
                end else begin
                    cnt_next[i] = cnt[i] + CW'(1);
                end
            end
        end
    end

    // The pulses are computed from deb_next against deb. They are therefore
    // registered on the same edge that toggles IO_input, and they are high
    // during the cycle that follows that edge.
    always_ff @(posedge physical_clock) begin
        if (reset) begin
            sync1       <= '0;
            sync2       <= '0;
            deb         <= '0;
            cnt         <= '0;
            press_q     <= '0;
            release_q   <= '0;
            sw_change_q <= 1'b0;
        end else begin
            sync1       <= raw_hi;
            sync2       <= sync1;
            deb         <= deb_next;
            cnt         <= cnt_next;
            press_q     <= deb_next[21:18] & ~deb[21:18];
            release_q   <= ~deb_next[21:18] & deb[21:18];
            sw_change_q <= |(deb_next[17:0] ^ deb[17:0]);
        end
    end

    assign io.IO_input          = deb;
    assign io.key_press_pulse   = press_q;
    assign io.key_release_pulse = release_q;
    assign io.sw_change         = sw_change_q;
endmodule

// File: doc/io_input_sampler.md
IO_INPUT_SAMPLER -- requirements
Module: io_input_sampler

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000 (10 ms at 50 MHz), legal range >= 2; sets the debounce stability window in clock cycles.
REQ-002 physical_clock  in  1  single 50 MHz clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 sw_raw  in  18  board slide switches, asynchronous, active-high.
REQ-005 key_raw  in  4  board push-buttons, asynchronous, active-low (0 = pressed).
REQ-006 IO_input  out  22  debounced inputs: [17:0] switches, [21:18] keys, active-high (1 = pressed); drives the datapath's IO_input.
REQ-007 key_press_pulse  out  4  one-cycle pulse per key on each debounced 0->1 of IO_input[18+i].
REQ-008 key_release_pulse  out  4  one-cycle pulse per key on each debounced 1->0 of IO_input[18+i].
REQ-009 sw_change  out  1  one-cycle pulse when any debounced switch bit changes.
REQ-010 All outputs SHALL be registered; no combinational path from any input to any output.

Function
REQ-011 Each of the 22 lines SHALL pass through a two-flop synchronizer; keys are inverted before the first flop so all internal levels are active-high.
REQ-012 Each line SHALL have an independent stability counter, width ceil(log2(DEBOUNCE_CYCLES)) bits, and an independent debounced state bit (IO_input bit).
REQ-013 Counter rule per line, per edge: sync2 == debounced -> counter <= 0; sync2 != debounced and counter < DEBOUNCE_CYCLES-1 -> counter increments; sync2 != debounced and counter == DEBOUNCE_CYCLES-1 -> debounced <= sync2, counter <= 0.
REQ-014 Latency: a raw level held stable SHALL appear on IO_input exactly DEBOUNCE_CYCLES+2 rising edges after the first edge that samples the new raw level.
REQ-015 Glitch rejection: a raw level held for DEBOUNCE_CYCLES-1 or fewer sampled edges SHALL NOT change IO_input and SHALL NOT produce any pulse.
REQ-016 Counters SHALL saturate by rule REQ-013 and SHALL never wrap.
REQ-017 key_press_pulse[i] and key_release_pulse[i] SHALL be high during exactly the one cycle following the edge at which IO_input[18+i] toggles, and low otherwise.
REQ-018 sw_change SHALL be high during exactly the one cycle following any edge at which one or more of IO_input[17:0] toggle; multiple simultaneous switch toggles produce one pulse.
REQ-019 Simultaneous events on different lines SHALL be handled independently in the same cycle; all resulting toggles and pulses coincide.
REQ-020 A new toggle on the same line requires a further full stability window; minimum spacing between two toggles of one line is DEBOUNCE_CYCLES edges.

Reset
REQ-021 While reset is high at an edge: switch synchronizer flops <= 0, key synchronizer flops <= 0 (internal idle = not pressed), all counters <= 0, IO_input <= 0, all pulse outputs <= 0.
REQ-022 Reset asserted mid-count SHALL discard the pending count; no toggle or pulse is emitted for that event.
REQ-023 After reset deasserts, an input already at an active level SHALL be re-debounced from scratch with full REQ-014 latency, producing the corresponding press pulse or sw_change.
REQ-024 No pulse SHALL be emitted on the cycle reset deasserts.

Verification (bench uses DEBOUNCE_CYCLES = 4)
REQ-025 Reset: sw_raw=0, key_raw=4'hF, reset high 3 cycles -> IO_input=22'h0, all pulses 0, held after release.
REQ-026 Switch: sw_raw[5] 0->1 held -> IO_input[5]=1 at edge 6 after first sampling edge; sw_change high exactly one cycle; other bits 0.
REQ-027 Glitch: key_raw[0] low for 3 edges, then high -> IO_input[18] stays 0, key_press_pulse and key_release_pulse stay 0.
REQ-028 Press/release: key_raw[2] low for 10 cycles, then high -> IO_input[20]=1 at edge 6 with key_press_pulse[2] one cycle; IO_input[20]=0 six edges after release with key_release_pulse[2] one cycle.
REQ-029 Simultaneous: sw_raw[0] 0->1 and key_raw[3] 1->0 on the same cycle -> IO_input[0] and IO_input[21] set on the same edge; sw_change and key_press_pulse[3] pulse together.
REQ-030 Reset mid-count: key_raw[1] low, reset pulsed at the 3rd edge, key held low -> no pulse during or after reset before IO_input[19]=1 at edge 6 counted from the first edge after reset deasserts, then key_press_pulse[1] pulses once.
